spi_flash_xip_apb: RTL and testbench

//  APB slave giving execute-in-place read access to a serial NOR flash. It drives SPI mode 0 pins

---
 rtl/spi_flash_xip_apb_if.sv | 23 ++
 rtl/spi_flash_xip_apb.sv | 188 ++++++++++++++++++
 tb/tb_spi_flash_xip_apb.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_xip_apb_if.sv
// APB bus bundle for the flash XIP port; the master drives the request, the slave answers.
interface spi_flash_xip_apb_if;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    modport master (
        output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );

    modport slave (
        input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr
    );
endinterface

// File: rtl/spi_flash_xip_apb.sv
// Execute-in-place APB read port for a serial NOR flash: READ 0x03 + 24-bit address per miss,
// SPI mode 0 pins driven directly, optional one-word buffer for repeat reads.
//
// state | meaning
// IDLE  | wait for psel&penable, decode hit / miss / error
// SETUP | SS low, SCK low, first MOSI bit presented for CLK_DIV cycles
// SHIFT | 64 SCK periods: 32 command/address bits out, 32 data bits in
// HOLD  | SS released for CLK_DIV cycles, word and buffer captured
// RESP  | one-cycle in_pready pulse
module spi_flash_xip_apb #(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_MASK = 32'h0fff_ffff,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned SS_NUM     = 8,
    parameter int unsigned FLASH_SS   = 0,
    parameter bit          BUF_EN     = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_flash_xip_apb_if.slave   apb,
    output logic                 spi_sck,
    output logic [SS_NUM-1:0]    spi_ss,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_RESP} state_t;

    localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

    state_t       state, state_d;
    logic [7:0]   div_cnt, div_d;
    logic [5:0]   bit_cnt, bit_d;
    logic         sck_q, sck_d;
    logic         ss_n_q, ss_n_d;
    logic [63:0]  sh_q, sh_d;
    logic [31:0]  rx_q, rx_d;
    logic [21:0]  addr_q, addr_d;
    logic         err_q, err_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         buf_valid, buf_valid_d;
    logic [21:0]  buf_tag, buf_tag_d;
    logic [31:0]  buf_data, buf_data_d;

    logic         in_window;
    logic         buf_hit;
    logic         div_tc;
    logic [31:0]  rx_word;
    logic         unused_apb;

    assign in_window = (apb.in_paddr & ~FLASH_MASK) == FLASH_BASE;
    assign buf_hit   = BUF_EN && buf_valid && (buf_tag == apb.in_paddr[23:2]);
    assign div_tc    = (div_cnt == 8'd0);
    // First byte off the wire lands in the low byte of the word.
    assign rx_word   = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
    assign unused_apb = ^{apb.in_pprot, apb.in_pwdata, apb.in_pstrb};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            div_cnt   <= 8'd0;
            bit_cnt   <= 6'd0;
            sck_q     <= 1'b0;
            ss_n_q    <= 1'b1;
            sh_q      <= 64'd0;
            rx_q      <= 32'd0;
            addr_q    <= 22'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            buf_valid <= 1'b0;
            buf_tag   <= 22'd0;
            buf_data  <= 32'd0;
        end else begin
            state     <= state_d;
            div_cnt   <= div_d;
            bit_cnt   <= bit_d;
            sck_q     <= sck_d;
            ss_n_q    <= ss_n_d;
            sh_q      <= sh_d;
            rx_q      <= rx_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            buf_valid <= buf_valid_d;
            buf_tag   <= buf_tag_d;
            buf_data  <= buf_data_d;
        end
    end

    always_comb begin
        state_d     = state;
        div_d       = div_cnt;
        bit_d       = bit_cnt;
        sck_d       = sck_q;
        ss_n_d      = ss_n_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        buf_valid_d = buf_valid;
        buf_tag_d   = buf_tag;
        buf_data_d  = buf_data;

        case (state)
            ST_IDLE: begin
                if (apb.in_psel && apb.in_penable) begin
                    addr_d = apb.in_paddr[23:2];
                    if (apb.in_pwrite || !in_window) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_RESP;
                    end else if (buf_hit) begin
                        err_d   = 1'b0;
                        rdata_d = buf_data;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        ss_n_d  = 1'b0;
                        sh_d    = {8'h03, apb.in_paddr[23:2], 2'b00, 32'd0};
                        div_d   = DIV_LD;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (div_tc) begin
                    div_d   = DIV_LD;
                    bit_d   = 6'd63;
                    sck_d   = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_cnt - 8'd1;
                end
            end
            ST_SHIFT: begin
                if (!div_tc) begin
                    div_d = div_cnt - 8'd1;
                end else begin
                    div_d = DIV_LD;
                    if (!sck_q) begin
                        // Rising edge: flash output is stable, capture it.
                        sck_d = 1'b1;
                        rx_d  = {rx_q[30:0], spi_miso};
                    end else if (bit_cnt == 6'd0) begin
                        sck_d       = 1'b0;
                        ss_n_d      = 1'b1;
                        rdata_d     = rx_word;
                        buf_valid_d = 1'b1;
                        buf_tag_d   = addr_q;
                        buf_data_d  = rx_word;
                        state_d     = ST_HOLD;
                    end else begin
                        sck_d = 1'b0;
                        sh_d  = {sh_q[62:0], 1'b0};
                        bit_d = bit_cnt - 6'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (div_tc) begin
                    state_d = ST_RESP;
                end else begin
                    div_d = div_cnt - 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign apb.in_pready  = (state == ST_RESP);
    assign apb.in_prdata  = (state == ST_RESP) ? rdata_q : 32'd0;
    assign apb.in_pslverr = (state == ST_RESP) && err_q;

    assign spi_sck  = sck_q;
    assign spi_mosi = sh_q[63];

    always_comb begin
        spi_ss           = '1;
        spi_ss[FLASH_SS] = ss_n_q;
    end

endmodule

// File: tb/tb_spi_flash_xip_apb.sv
// Randomized scoreboard bench: two DUTs (CLK_DIV=1 buffered, CLK_DIV=4 unbuffered) against a flash model.
module tb_spi_flash_xip_apb;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'h0fff_ffff;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          frames;
        logic [63:0] frame;
        int          stamp;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    logic rst_q = 1'b1;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    logic [31:0] paddr_r [2];
    logic        psel_r [2];
    logic        penable_r [2];
    logic        pwrite_r [2];
    logic [31:0] junk_r;

    logic        sck0, sck1, mosi0, mosi1;
    logic [7:0]  ss0, ss1;
    logic [1:0]  miso_r = 2'b00;
    logic        sck_v [2];
    logic        mosi_v [2];
    logic [7:0]  ss_v [2];
    logic        pready_v [2];
    logic [31:0] prdata_v [2];
    logic        pslverr_v [2];

    spi_flash_xip_apb_if apb0 ();
    spi_flash_xip_apb_if apb1 ();

    assign apb0.in_paddr   = paddr_r[0];
    assign apb0.in_psel    = psel_r[0];
    assign apb0.in_penable = penable_r[0];
    assign apb0.in_pwrite  = pwrite_r[0];
    assign apb0.in_pprot   = junk_r[2:0];
    assign apb0.in_pwdata  = junk_r;
    assign apb0.in_pstrb   = junk_r[7:4];
    assign apb1.in_paddr   = paddr_r[1];
    assign apb1.in_psel    = psel_r[1];
    assign apb1.in_penable = penable_r[1];
    assign apb1.in_pwrite  = pwrite_r[1];
    assign apb1.in_pprot   = junk_r[5:3];
    assign apb1.in_pwdata  = ~junk_r;
    assign apb1.in_pstrb   = junk_r[11:8];

    assign sck_v[0] = sck0;   assign sck_v[1] = sck1;
    assign mosi_v[0] = mosi0; assign mosi_v[1] = mosi1;
    assign ss_v[0] = ss0;     assign ss_v[1] = ss1;
    assign pready_v[0] = apb0.in_pready;   assign pready_v[1] = apb1.in_pready;
    assign prdata_v[0] = apb0.in_prdata;   assign prdata_v[1] = apb1.in_prdata;
    assign pslverr_v[0] = apb0.in_pslverr; assign pslverr_v[1] = apb1.in_pslverr;

    spi_flash_xip_apb #(.CLK_DIV(1), .BUF_EN(1'b1)) dut0 (
        .clock(clock), .reset(reset), .apb(apb0),
        .spi_sck(sck0), .spi_ss(ss0), .spi_mosi(mosi0), .spi_miso(miso_r[0])
    );

    spi_flash_xip_apb #(.CLK_DIV(4), .BUF_EN(1'b0)) dut1 (
        .clock(clock), .reset(reset), .apb(apb1),
        .spi_sck(sck1), .spi_ss(ss1), .spi_mosi(mosi1), .spi_miso(miso_r[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    function automatic int dv(input int p);
        return (p == 0) ? 1 : 4;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000104: return 8'h11;
            24'h000105: return 8'h22;
            24'h000106: return 8'h33;
            24'h000107: return 8'h44;
            default:    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [23:0] w;
        w = {a[23:2], 2'b00};
        return {mem_byte(w + 24'd3), mem_byte(w + 24'd2), mem_byte(w + 24'd1), mem_byte(w)};
    endfunction

    // Flash model: watches pin edges just after each clock edge, counts them, answers with memory bytes.
    logic [63:0] frame_r [2];
    int          nbit [2]   = '{0, 0};
    int          rises [2]  = '{0, 0};
    int          falls [2]  = '{0, 0};
    int          bad [2]    = '{0, 0};
    int          t_edge [2] = '{0, 0};
    logic [23:0] cap_a [2];
    logic        prev_sck [2] = '{1'b0, 1'b0};
    logic        prev_ss [2]  = '{1'b1, 1'b1};

    always @(posedge clock) begin : flash
        logic       s, c;
        logic [7:0] b;
        int         k;
        #1;
        for (int p = 0; p < 2; p++) begin
            s = ss_v[p][0];
            c = sck_v[p];
            if (s === 1'b0 && prev_ss[p] === 1'b1) begin
                falls[p]++;
                nbit[p]   = 0;
                t_edge[p] = cyc + dv(p);
                miso_r[p] = 1'b0;
            end
            if (c === 1'b1 && prev_sck[p] === 1'b0) begin
                if (cyc - t_edge[p] != dv(p)) bad[p]++;
                t_edge[p]  = cyc;
                frame_r[p] = {frame_r[p][62:0], mosi_v[p]};
                nbit[p]++;
                rises[p]++;
                if (nbit[p] == 32) cap_a[p] = frame_r[p][23:0];
            end
            if (c === 1'b0 && prev_sck[p] === 1'b1) begin
                if (cyc - t_edge[p] != dv(p)) bad[p]++;
                t_edge[p] = cyc;
                if (nbit[p] >= 32 && nbit[p] < 64) begin
                    k = nbit[p] - 32;
                    b = mem_byte(cap_a[p] + 24'(k / 8));
                    miso_r[p] = b[7 - (k % 8)];
                end else begin
                    miso_r[p] = 1'b0;
                end
            end
            prev_ss[p]  = s;
            prev_sck[p] = c;
        end
    end

    task automatic chk(input string nm, input int p, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s port%0d: got %0h expected %0h (cycle %0d)", nm, p, act, exp_v, cyc);
        end
    endtask

    int snap_falls [2] = '{0, 0};
    int snap_rises [2] = '{0, 0};
    int snap_bad [2]   = '{0, 0};

    always @(negedge clock) begin : monitor
        exp_t e;
        if (rst_q) begin
            for (int p = 0; p < 2; p++) begin
                chk("reset_state", p,
                    64'({ss_v[p], sck_v[p], mosi_v[p], pready_v[p], pslverr_v[p], prdata_v[p]}),
                    64'({8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}));
                snap_falls[p] = falls[p];
                snap_rises[p] = rises[p];
                snap_bad[p]   = bad[p];
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                chk("ss_other_bits", p, 64'(ss_v[p][7:1]), 64'(7'h7F));
                if (pready_v[p] === 1'b1) begin
                    if (exp_q.size() == 0 || exp_q[0].port != p) begin
                        chk("unexpected_pready", p, 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", p, 64'(cyc - e.stamp), 64'(e.lat));
                        chk("pslverr", p, 64'(pslverr_v[p]), 64'(e.err));
                        if (!e.err) chk("prdata", p, 64'(prdata_v[p]), 64'(e.rdata));
                        chk("ss_frames", p, 64'(falls[p] - snap_falls[p]), 64'(e.frames));
                        chk("sck_rises", p, 64'(rises[p] - snap_rises[p]), 64'(64 * e.frames));
                        chk("sck_widths", p, 64'(bad[p] - snap_bad[p]), 64'd0);
                        if (e.frames == 1) chk("mosi_frame", p, frame_r[p], e.frame);
                    end
                    snap_falls[p] = falls[p];
                    snap_rises[p] = rises[p];
                    snap_bad[p]   = bad[p];
                end else begin
                    chk("idle_outputs", p, 64'({pready_v[p], pslverr_v[p], prdata_v[p]}), 64'd0);
                end
            end
            if (exp_q.size() != 0 && cyc - exp_q[0].stamp > exp_q[0].lat + 8) begin
                e = exp_q.pop_front();
                chk("response_timeout", e.port, 64'(cyc - e.stamp), 64'(e.lat));
            end
        end
    end

    // Reference model state: what the buffer should currently hold.
    bit          bv [2]  = '{1'b0, 1'b0};
    logic [21:0] tag [2];

    task automatic access(input int p, input logic [31:0] a, input logic w);
        exp_t e;
        int   n;
        @(negedge clock);
        junk_r       = $urandom;
        paddr_r[p]   = a;
        pwrite_r[p]  = w;
        psel_r[p]    = 1'b1;
        penable_r[p] = 1'b0;
        @(negedge clock);
        penable_r[p] = 1'b1;
        e.port  = p;
        e.stamp = cyc;
        e.rdata = 32'd0;
        e.frame = 64'd0;
        if (w || (a & ~MASK) != BASE) begin
            e.err = 1'b1; e.lat = 1; e.frames = 0;
        end else if (p == 0 && bv[p] && tag[p] == a[23:2]) begin
            e.err = 1'b0; e.lat = 1; e.frames = 0; e.rdata = ref_word(a);
        end else begin
            e.err = 1'b0; e.lat = 130 * dv(p) + 1; e.frames = 1; e.rdata = ref_word(a);
            e.frame = {8'h03, a[23:2], 2'b00, 32'd0};
            bv[p]  = 1'b1;
            tag[p] = a[23:2];
        end
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (pready_v[p] !== 1'b1) begin
                paddr_r[p]  = $urandom;
                pwrite_r[p] = 1'($urandom_range(0, 1));
            end
        end while (pready_v[p] !== 1'b1 && n < 2000);
        psel_r[p]    = 1'b0;
        penable_r[p] = 1'b0;
    endtask

    task automatic idle_junk(input int n);
        int p, m;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            p = $urandom_range(0, 1);
            m = $urandom_range(0, 2);
            paddr_r[p]   = BASE | 32'($urandom_range(0, 255) * 4);
            pwrite_r[p]  = 1'b0;
            psel_r[p]    = (m == 1);
            penable_r[p] = (m == 2);
        end
        @(negedge clock);
        for (int p2 = 0; p2 < 2; p2++) begin
            psel_r[p2]    = 1'b0;
            penable_r[p2] = 1'b0;
        end
    endtask

    logic [31:0] pool [4] = '{32'h0000_0104, 32'h0000_2000, 32'h00AB_CDE0, 32'h00FF_FFF0};

    initial begin
        int          p, kind;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            paddr_r[i] = 32'd0; psel_r[i] = 1'b0; penable_r[i] = 1'b0; pwrite_r[i] = 1'b0;
        end
        junk_r = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        access(0, 32'h3000_0104, 1'b0);
        access(0, 32'h3000_0104, 1'b0);
        access(0, 32'h3000_0107, 1'b0);
        access(0, 32'h3000_0000, 1'b1);
        access(0, 32'h1000_2000, 1'b0);
        access(1, 32'h30FF_FFFC, 1'b0);
        access(1, 32'h30FF_FFFC, 1'b0);

        // Abort a miss mid-shift with reset; the buffer must come back empty.
        access(0, 32'h3000_0200, 1'b0);
        @(negedge clock);
        paddr_r[0] = 32'h3000_0300; pwrite_r[0] = 1'b0; psel_r[0] = 1'b1; penable_r[0] = 1'b0;
        @(negedge clock);
        penable_r[0] = 1'b1;
        repeat (40) @(negedge clock);
        reset = 1'b1; psel_r[0] = 1'b0; penable_r[0] = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        bv[0] = 1'b0; bv[1] = 1'b0;
        access(0, 32'h3000_0200, 1'b0);

        for (int i = 0; i < 40; i++) begin
            p    = ($urandom_range(0, 9) == 0) ? 1 : 0;
            kind = $urandom_range(0, 9);
            a    = BASE | (32'($urandom_range(0, 15)) << 24) | pool[$urandom_range(0, 3)]
                   | 32'($urandom_range(0, 3));
            if (kind == 6 || kind == 7) begin
                a = $urandom;
                if (a[31:28] == 4'h3) a[31:28] = 4'h7;
            end
            access(p, a, kind >= 8);
            idle_junk($urandom_range(0, 3));
        end

        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clock);
        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
